// File: rtl/wt_synth_pkg.sv
// Shared constants and the table-lookup helper for the wavetable oscillator.
// The optional interpolation build (macro WT_INTERP_EN) uses the same definitions.
package wt_synth_pkg;

  localparam int CTRL_OSC_EN      = 0;
  localparam int CTRL_STREAM_MODE = 1;
  localparam int CTRL_SW_GATE     = 2;

  localparam int PHASE_W     = 24;
  localparam int SAMPLE_W    = 8;
  localparam int NUM_SAMPLES = 8;
  localparam int IDX_W       = 3;

  // Entry i of the flattened table occupies bits [8*i+7:8*i].
  function automatic logic [SAMPLE_W-1:0] table_sample(
    input logic [NUM_SAMPLES*SAMPLE_W-1:0] wt,
    input logic [IDX_W-1:0]                idx
  );
    return wt[idx*SAMPLE_W +: SAMPLE_W];
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: tick is high for one clk while the count
// sits at SAMPLE_DIV-1, after which the count wraps to zero.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(SAMPLE_DIV - 1));

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wavetable_oscillator.sv
// Wavetable oscillator: 24-bit phase accumulator, 8-entry table lookup, volume scaling.
// Build option WT_INTERP_EN adds linear interpolation between adjacent entries (one extra stage).
module wavetable_oscillator
  import wt_synth_pkg::*;
#(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      reg_control,
  input  logic [7:0]                      reg_freq_low,
  input  logic [7:0]                      reg_freq_mid,
  input  logic [7:0]                      reg_freq_high,
  input  logic [7:0]                      reg_volume,
  input  logic [NUM_SAMPLES*SAMPLE_W-1:0] wavetable,
  input  logic                            ext_gate,
  output logic [SAMPLE_W-1:0]             sample_out,
  output logic                            sample_valid,
  output logic                            status_gate_active,
  output logic                            status_osc_running
);

  logic                  tick;
  logic                  osc_en, stream_mode, gate, advance, audible;
  logic [PHASE_W-1:0]    freq, phase;
  logic [IDX_W-1:0]      idx;
  logic [SAMPLE_W-1:0]   raw, mul_src;
  logic [2*SAMPLE_W-1:0] product;
  logic                  lookup_valid, out_stage;
  logic                  unused_bits;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign osc_en      = reg_control[CTRL_OSC_EN];
  assign stream_mode = reg_control[CTRL_STREAM_MODE];
  assign gate        = reg_control[CTRL_SW_GATE] | ext_gate;
  assign advance     = osc_en & ~stream_mode & gate;
  // Stream mode ignores OSC_EN, but both paths stay silent without the gate.
  assign audible     = gate & (stream_mode | osc_en);
  assign freq        = {reg_freq_high, reg_freq_mid, reg_freq_low};
  assign idx         = phase[PHASE_W-1 -: IDX_W];
  assign product     = mul_src * reg_volume;

`ifdef WT_INTERP_EN
  logic [SAMPLE_W-1:0]          s0, s1, frac, raw_q;
  logic signed [SAMPLE_W:0]     diff;
  logic signed [2*SAMPLE_W+1:0] delta_scaled;
  logic                         interp_valid;

  assign s0           = table_sample(wavetable, idx);
  assign s1           = table_sample(wavetable, idx + IDX_W'(1));
  assign frac         = phase[PHASE_W-IDX_W-1 -: SAMPLE_W];
  assign diff         = $signed({1'b0, s1}) - $signed({1'b0, s0});
  assign delta_scaled = diff * $signed({1'b0, frac});
  // Bits [15:8] are the low byte of (diff*frac)>>>8; the true sum lies in 0..255, so a byte add is exact.
  assign raw          = stream_mode ? table_sample(wavetable, IDX_W'(0))
                                    : s0 + delta_scaled[2*SAMPLE_W-1:SAMPLE_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q        <= '0;
      interp_valid <= 1'b0;
    end else begin
      interp_valid <= lookup_valid;
      if (lookup_valid) raw_q <= raw;
    end
  end

  assign mul_src     = raw_q;
  assign out_stage   = interp_valid;
  assign unused_bits = ^{reg_control[7:3], product[SAMPLE_W-1:0],
                         delta_scaled[2*SAMPLE_W+1:2*SAMPLE_W], delta_scaled[SAMPLE_W-1:0]};
`else
  assign raw         = stream_mode ? table_sample(wavetable, IDX_W'(0))
                                   : table_sample(wavetable, idx);
  assign mul_src     = raw;
  assign out_stage   = lookup_valid;
  assign unused_bits = ^{reg_control[7:3], product[SAMPLE_W-1:0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase              <= '0;
      lookup_valid       <= 1'b0;
      sample_valid       <= 1'b0;
      sample_out         <= '0;
      status_gate_active <= 1'b0;
      status_osc_running <= 1'b0;
    end else begin
      lookup_valid       <= tick;
      sample_valid       <= out_stage;
      status_gate_active <= gate;
      status_osc_running <= advance;
      if (tick) begin
        if (advance)      phase <= phase + freq;
        else if (!osc_en) phase <= '0;
      end
      if (out_stage) sample_out <= audible ? product[2*SAMPLE_W-1:SAMPLE_W] : '0;
    end
  end

endmodule
